// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands/control, generates the ALU code,
// inserts load-use bubbles. Define ID_EX_FORWARD_EN to enable EX/MEM and MEM/WB operand forwarding.
module id_ex_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [5:0]  id_funct,
  input  logic [1:0]  id_alu_op,
  input  logic [5:0]  id_ctrl,
  input  logic        flush,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic        hazard_stall,
  output logic        ex_valid,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [31:0] ex_rt_data,
  output logic [4:0]  ex_dest,
  output logic [3:0]  ex_ctrl
);

  logic        r_valid;
  logic [3:0]  r_alu_control;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [31:0] r_imm;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_dest;
  logic        r_alu_src;
  logic [3:0]  r_ctrl;

  logic [3:0]  w_alu_code;
  logic        w_bubble;
  logic [31:0] w_fwd_a;
  logic [31:0] w_fwd_b;

  // ALU control code from alu_op, with funct decode for R-type
  always_comb begin
    w_alu_code = 4'b1111;
    case (id_alu_op)
      2'b00: w_alu_code = 4'b0010;
      2'b01: w_alu_code = 4'b0110;
      2'b10: begin
        case (id_funct)
          6'b100000: w_alu_code = 4'b0010;
          6'b100010: w_alu_code = 4'b0110;
          6'b100100: w_alu_code = 4'b0000;
          6'b100101: w_alu_code = 4'b0001;
          6'b101010: w_alu_code = 4'b0111;
          6'b100111: w_alu_code = 4'b1100;
          default:   w_alu_code = 4'b1111;
        endcase
      end
      default: w_alu_code = 4'b1111;
    endcase
  end

  // ctrl bit 3 of the registered field is mem_read
  assign hazard_stall = id_valid & r_valid & r_ctrl[3] & (r_dest != 5'd0) &
                        ((r_dest == id_rs) | (r_dest == id_rt));

  assign w_bubble = flush | hazard_stall | ~id_valid;

  always_ff @(posedge clock) begin
    if (reset || w_bubble) begin
      r_valid       <= 1'b0;
      r_alu_control <= 4'd0;
      r_rs_data     <= 32'd0;
      r_rt_data     <= 32'd0;
      r_imm         <= 32'd0;
      r_rs          <= 5'd0;
      r_rt          <= 5'd0;
      r_dest        <= 5'd0;
      r_alu_src     <= 1'b0;
      r_ctrl        <= 4'd0;
    end else begin
      r_valid       <= 1'b1;
      r_alu_control <= w_alu_code;
      r_rs_data     <= id_rs_data;
      r_rt_data     <= id_rt_data;
      r_imm         <= id_imm;
      r_rs          <= id_rs;
      r_rt          <= id_rt;
      r_dest        <= id_ctrl[4] ? id_rd : id_rt;
      r_alu_src     <= id_ctrl[5];
      r_ctrl        <= id_ctrl[3:0];
    end
  end

`ifdef ID_EX_FORWARD_EN
  // EX/MEM has priority over MEM/WB; register 0 is never forwarded
  always_comb begin
    w_fwd_a = r_rs_data;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == r_rs))
      w_fwd_a = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == r_rs))
      w_fwd_a = memwb_result;
  end

  always_comb begin
    w_fwd_b = r_rt_data;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == r_rt))
      w_fwd_b = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == r_rt))
      w_fwd_b = memwb_result;
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result, r_rs};
  assign w_fwd_a = r_rs_data;
  assign w_fwd_b = r_rt_data;
`endif

  assign alu_in1     = w_fwd_a;
  assign alu_in2     = r_alu_src ? r_imm : w_fwd_b;
  assign ex_rt_data  = w_fwd_b;
  assign ex_valid    = r_valid;
  assign alu_control = r_alu_control;
  assign ex_dest     = r_dest;
  assign ex_ctrl     = r_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed test-plan cycles followed by random traffic,
// checked against a transaction-level model of the EX slot.
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_ctrl;
  logic        flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        hazard_stall, ex_valid;
  logic [3:0]  alu_control, ex_ctrl;
  logic [31:0] alu_in1, alu_in2, ex_rt_data;
  logic [4:0]  ex_dest;

  id_ex_stage dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .id_alu_op(id_alu_op), .id_ctrl(id_ctrl), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .alu_control(alu_control),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .ex_rt_data(ex_rt_data),
    .ex_dest(ex_dest), .ex_ctrl(ex_ctrl)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, valid, flush;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct, ctrl;
    logic [1:0]  op;
    logic        exw, memw;
    logic [4:0]  exrd, memrd;
    logic [31:0] exres, memres;
  } stim_t;

  // Instruction currently sitting in EX, as a plain record (null instr = all zero)
  typedef struct {
    logic        valid, alu_src, reg_dst, mem_read;
    logic [3:0]  code, ctrl;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, dest;
  } instr_t;

  typedef struct {
    logic        hz, valid;
    logic [3:0]  code, ctrl;
    logic [31:0] in1, in2, rtd;
    logic [4:0]  dest;
  } exp_t;

  exp_t   sb_q[$];
  instr_t m;
  int     n_pass = 0;
  int     n_total = 0;
  bit     done = 0;

  function automatic logic [3:0] ref_code(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b1111;
    if (f == 6'd32) return 4'b0010;   // add
    if (f == 6'd34) return 4'b0110;   // sub
    if (f == 6'd36) return 4'b0000;   // and
    if (f == 6'd37) return 4'b0001;   // or
    if (f == 6'd42) return 4'b0111;   // slt
    if (f == 6'd39) return 4'b1100;   // nor
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_operand(input stim_t s, input logic [4:0] idx,
                                              input logic [31:0] regval);
`ifdef ID_EX_FORWARD_EN
    if (idx != 0 && s.exw && s.exrd == idx) return s.exres;
    if (idx != 0 && s.memw && s.memrd == idx) return s.memres;
`endif
    return regval;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle, record what the DUT must show during it, advance the model
  task automatic apply(input stim_t s);
    exp_t   e;
    instr_t nx;
    logic   load_use;
    logic [31:0] b;
    @(negedge clock);
    reset = s.rst; id_valid = s.valid; flush = s.flush;
    id_rs_data = s.rs_data; id_rt_data = s.rt_data; id_imm = s.imm;
    id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; id_funct = s.funct;
    id_alu_op = s.op; id_ctrl = s.ctrl;
    exmem_reg_write = s.exw; exmem_rd = s.exrd; exmem_result = s.exres;
    memwb_reg_write = s.memw; memwb_rd = s.memrd; memwb_result = s.memres;

    load_use = s.valid && m.valid && m.mem_read && m.dest != 0 &&
               (m.dest == s.rs || m.dest == s.rt);
    b = ref_operand(s, m.rt, m.rt_data);
    e.hz = load_use; e.valid = m.valid; e.code = m.code; e.ctrl = m.ctrl;
    e.in1 = ref_operand(s, m.rs, m.rs_data);
    e.rtd = b;
    e.in2 = m.alu_src ? m.imm : b;
    e.dest = m.dest;
    sb_q.push_back(e);

    nx = '{default: '0};
    if (!s.rst && !s.flush && !load_use && s.valid) begin
      nx.valid = 1; nx.alu_src = s.ctrl[5]; nx.reg_dst = s.ctrl[4];
      nx.mem_read = s.ctrl[3]; nx.ctrl = s.ctrl[3:0];
      nx.code = ref_code(s.op, s.funct);
      nx.rs_data = s.rs_data; nx.rt_data = s.rt_data; nx.imm = s.imm;
      nx.rs = s.rs; nx.rt = s.rt; nx.dest = s.ctrl[4] ? s.rd : s.rt;
    end
    m = nx;
  endtask

  // Monitor: compare the DUT against each scoreboard entry once outputs settle
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clock);
      #2;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("hazard_stall", 32'(hazard_stall), 32'(e.hz));
        check("ex_valid",     32'(ex_valid),     32'(e.valid));
        check("alu_control",  32'(alu_control),  32'(e.code));
        check("ex_ctrl",      32'(ex_ctrl),      32'(e.ctrl));
        check("ex_dest",      32'(ex_dest),      32'(e.dest));
        check("alu_in1",      alu_in1,           e.in1);
        check("alu_in2",      alu_in2,           e.in2);
        check("ex_rt_data",   ex_rt_data,        e.rtd);
      end
    end
  end

  initial begin
    stim_t s;
    int wait_cycles;
    m = '{default: '0};
    s = idle_stim();
    reset = 1; id_valid = 0; flush = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_funct = 0; id_alu_op = 0; id_ctrl = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    repeat (2) @(posedge clock);

    // Post-reset idle
    apply(s);
    // R-type slt
    s = idle_stim(); s.valid = 1; s.op = 2'b10; s.funct = 6'b101010;
    s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd8; s.rs_data = 5; s.rt_data = 9; s.ctrl = 6'b010010;
    apply(s);
    // Load into r3, then a consumer of r3 (stall), then the retried consumer
    s = idle_stim(); s.valid = 1; s.op = 2'b00; s.rs = 5'd5; s.rt = 5'd3;
    s.imm = 32'd16; s.ctrl = 6'b101011;
    apply(s);
    s = idle_stim(); s.valid = 1; s.op = 2'b10; s.funct = 6'b100000;
    s.rs = 5'd3; s.rt = 5'd6; s.rd = 5'd7; s.rs_data = 32'hA; s.rt_data = 32'hB; s.ctrl = 6'b010010;
    apply(s);
    apply(s);
    // Instruction with rs = 4 held while forwarding sources vary
    s = idle_stim(); s.valid = 1; s.op = 2'b10; s.funct = 6'b100000;
    s.rs = 5'd4; s.rt = 5'd9; s.rd = 5'd10; s.rs_data = 32'h99; s.rt_data = 32'h77; s.ctrl = 6'b010010;
    apply(s);
    s.exw = 1; s.exrd = 5'd4; s.exres = 32'h11; s.memw = 1; s.memrd = 5'd4; s.memres = 32'h22;
    apply(s);
    s.exrd = 5'd0;
    apply(s);
    // Immediate operand with rt forwarded from MEM/WB
    s = idle_stim(); s.valid = 1; s.op = 2'b00; s.rs = 5'd2; s.rt = 5'd9;
    s.imm = 32'hFFFF_FFFC; s.rt_data = 32'h55; s.ctrl = 6'b100010;
    apply(s);
    s = idle_stim(); s.memw = 1; s.memrd = 5'd9; s.memres = 32'hCAFE;
    // Flushed add, then illegal funct
    s.valid = 1; s.flush = 1; s.op = 2'b10; s.funct = 6'b100000; s.rs = 5'd1; s.rt = 5'd2;
    s.rd = 5'd3; s.ctrl = 6'b010010;
    apply(s);
    s = idle_stim(); s.valid = 1; s.op = 2'b10; s.funct = 6'b000000; s.rd = 5'd1; s.ctrl = 6'b010010;
    apply(s);
    // Load followed by stalled consumer with reset on the stall cycle
    s = idle_stim(); s.valid = 1; s.rt = 5'd12; s.ctrl = 6'b101011;
    apply(s);
    s = idle_stim(); s.valid = 1; s.rs = 5'd12; s.rt = 5'd13; s.rd = 5'd14; s.ctrl = 6'b010010;
    s.rst = 1;
    apply(s);
    s.rst = 0;
    apply(s);

    // Random traffic with small register indices to provoke hazards and forwarding
    for (int i = 0; i < 600; i++) begin
      s.rst     = ($urandom_range(0, 49) == 0);
      s.valid   = ($urandom_range(0, 5) != 0);
      s.flush   = ($urandom_range(0, 9) == 0);
      s.rs_data = $urandom; s.rt_data = $urandom; s.imm = $urandom;
      s.rs = 5'($urandom_range(0, 7)); s.rt = 5'($urandom_range(0, 7));
      s.rd = 5'($urandom_range(0, 7));
      s.funct = ($urandom_range(0, 1) == 0) ? 6'($urandom) :
                6'(32 + 2 * $urandom_range(0, 5));
      s.op = 2'($urandom); s.ctrl = 6'($urandom);
      s.exw = 1'($urandom); s.exrd = 5'($urandom_range(0, 7)); s.exres = $urandom;
      s.memw = 1'($urandom); s.memrd = 5'($urandom_range(0, 7)); s.memres = $urandom;
      apply(s);
    end

    wait_cycles = 0;
    while (sb_q.size() != 0 && wait_cycles < 20) begin
      @(negedge clock);
      wait_cycles++;
    end
    #3;
    done = 1;
    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the ALU and drives its Control, Input1 and Input2 ports. It registers decoded operands and control, and generates the 4-bit ALU control code from ALUOp/funct. It detects load-use hazards and inserts bubbles. Optionally, it forwards results from EX/MEM and MEM/WB onto the ALU operands.

## Interface
Parameters:
- none; all widths are fixed for 32-bit MIPS.

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_rs_data, id_rt_data  in  32  register file read data
- id_imm  in  32  sign-extended immediate
- id_rs, id_rt, id_rd  in  5  register indices
- id_funct  in  6  R-type funct field
- id_alu_op  in  2  00 add, 01 sub, 10 use funct, 11 illegal
- id_ctrl  in  6  {alu_src, reg_dst, mem_read, mem_write, reg_write, mem_to_reg}
- flush  in  1  kill the instruction entering EX (branch taken)
- exmem_reg_write, exmem_rd, exmem_result  in  1/5/32  EX/MEM writeback info
- memwb_reg_write, memwb_rd, memwb_result  in  1/5/32  MEM/WB writeback info
- hazard_stall  out  1  combinational; upstream holds PC and IF/ID when high
- ex_valid  out  1  registered valid
- alu_control  out  4  registered; drives ALU Control
- alu_in1, alu_in2  out  32  drive ALU Input1/Input2
- ex_rt_data  out  32  store data (rt after forwarding)
- ex_dest  out  5  registered destination: rd if reg_dst, else rt
- ex_ctrl  out  4  registered {mem_read, mem_write, reg_write, mem_to_reg}

## Operation
- ALU code from alu_op:
  - 00 → 0010
  - 01 → 0110
  - 11 → 1111
  - 10 → decode funct:
    - 100000 → 0010 (add)
    - 100010 → 0110 (sub)
    - 100100 → 0000 (and)
    - 100101 → 0001 (or)
    - 101010 → 0111 (slt)
    - 100111 → 1100 (nor)
    - any other funct → 1111
- Load-use hazard: hazard_stall = id_valid & ex_valid & ex_ctrl.mem_read & (ex_dest != 0) & ((ex_dest == id_rs) | (ex_dest == id_rt)).
- Register update priority at each edge:
  - reset: clear all state.
  - flush: load a bubble.
  - hazard_stall: load a bubble.
  - id_valid = 0: load a bubble.
  - otherwise: capture all id_* inputs and the computed ALU code.
- Bubble: every registered field is 0. So ex_valid = 0, ex_ctrl = 0, alu_control = 0000, and all operands/indices are 0. Downstream therefore performs no memory access and no writeback.
- Operand B select: alu_in2 = alu_src ? ex_imm : fwd_b. Always ex_rt_data = fwd_b.
- Forwarding for operand A (operand B is identical, using ex_rt and ex_rt_data):
  - If exmem_reg_write and exmem_rd != 0 and exmem_rd == ex_rs: use exmem_result.
  - Else if the same match holds on MEM/WB: use memwb_result.
  - Else: use the registered ex_rs_data.
  - EX/MEM wins when both stages match.
- Register 0 is never forwarded.

## Timing
- Latency: id_* inputs present in cycle N appear on the registered outputs in cycle N+1.
- alu_in1, alu_in2, ex_rt_data and hazard_stall are combinational from the registered state plus forwarding/id inputs. There are no added cycles.
- Reset values: every registered output is 0, so alu_control = 0000 and ex_dest = 0.
  - alu_in1 and alu_in2 are 0 during and after reset until the first valid capture.
  - hazard_stall is 0 while ex_valid = 0.
- A load-use stall lasts exactly one cycle: the bubble clears ex_valid, so hazard_stall drops in the next cycle.
- flush and hazard_stall asserted together: a bubble is loaded. hazard_stall remains a pure function of its inputs.
- Reset asserted mid-stall: state clears on that edge. No pending instruction is retained.

## Configuration
- ID_EX_FORWARD_EN defined: forwarding muxes are active as described.
- ID_EX_FORWARD_EN undefined: forwarding is removed.
  - alu_in1 = ex_rs_data; fwd_b = ex_rt_data.
  - exmem_* and memwb_* inputs are ignored.
  - Hazard detection and bubbles are unchanged.

## Test plan
- Reset held for 2 cycles, then released with id_valid = 0 → all registered outputs 0, alu_control = 0000, hazard_stall = 0.
- R-type funct 101010, rs_data = 5, rt_data = 9, reg_dst = 1, rd = 8 → next cycle alu_control = 0111, alu_in1 = 5, alu_in2 = 9, ex_dest = 8.
- Load with mem_read = 1 and rt = 3 in EX, id_rs = 3 with id_valid = 1 → hazard_stall = 1 that cycle. Next cycle ex_valid = 0, ex_ctrl = 0, hazard_stall = 0.
- ID_EX_FORWARD_EN defined, ex_rs = 4, exmem (reg_write = 1, rd = 4, result = 0x11), memwb (rd = 4, result = 0x22) → alu_in1 = 0x11. Repeat with exmem_rd = 0 → alu_in1 = 0x22.
- alu_src = 1, imm = 0xFFFFFFFC, alu_op = 00 → alu_control = 0010, alu_in2 = 0xFFFFFFFC, ex_rt_data = forwarded rt.
- flush = 1 together with a valid add → next cycle ex_valid = 0, alu_control = 0000. alu_op = 10 with funct 000000 → alu_control = 1111.
